muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative MIPS-I multiply/divide unit owning HI/LO (shift-add multiply, restoring divide).
// Optional macro MULDIV_ABORT_EN adds an abort input that cancels an operation in flight.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t               state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic                 is_div_r, is_div_s;
    logic                 neg_q_r, neg_q_s;
    logic                 neg_rem_r, neg_rem_s;
    logic [WIDTH-1:0]     dvsr_r, dvsr_s;
    logic [2*WIDTH-1:0]   acc_r, acc_s;
    logic [WIDTH-1:0]     hi_r, hi_s, lo_r, lo_s;
    logic                 busy_r, busy_s, done_r, done_s;

    logic                 abort_s;
    logic                 op_signed_s, op_md_s, op_div_s;
    logic                 a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_diff_s, rem_next_s;
    logic [2*WIDTH-1:0]   prod_fix_s;

`ifdef MULDIV_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign op_signed_s = (funct == F_MULT) || (funct == F_DIV);
    assign op_div_s    = (funct == F_DIV) || (funct == F_DIVU);
    assign op_md_s     = (funct == F_MULT) || (funct == F_MULTU) || op_div_s;
    assign a_neg_s     = op_signed_s & rs_val[WIDTH-1];
    assign b_neg_s     = op_signed_s & rt_val[WIDTH-1];
    assign a_mag_s     = a_neg_s ? neg_w(rs_val) : rs_val;
    assign b_mag_s     = b_neg_s ? neg_w(rt_val) : rt_val;

    // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
    assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, dvsr_r} : {(WIDTH+1){1'b0}});
    assign div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    assign div_ge_s    = (div_shift_s >= {1'b0, dvsr_r});
    assign div_diff_s  = div_shift_s[WIDTH-1:0] - dvsr_r;
    assign rem_next_s  = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
    assign prod_fix_s  = neg_q_r ? neg_2w(acc_r) : acc_r;

    // Next-state, datapath step and HI/LO update for every state.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        is_div_s  = is_div_r;
        neg_q_s   = neg_q_r;
        neg_rem_s = neg_rem_r;
        dvsr_s    = dvsr_r;
        acc_s     = acc_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !abort_s) begin
                    if (op_md_s) begin
                        is_div_s  = op_div_s;
                        neg_q_s   = a_neg_s ^ b_neg_s;
                        neg_rem_s = a_neg_s;
                        dvsr_s    = op_div_s ? b_mag_s : a_mag_s;
                        acc_s     = {{WIDTH{1'b0}}, (op_div_s ? a_mag_s : b_mag_s)};
                        cnt_s     = CW'(WIDTH - 1);
                        state_s   = RUN;
                    end else if (funct == F_MTHI) begin
                        hi_s = rs_val;
                    end else if (funct == F_MTLO) begin
                        lo_s = rs_val;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    if (is_div_r) begin
                        acc_s = {rem_next_s, acc_r[WIDTH-2:0], div_ge_s};
                    end else begin
                        acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
                    end
                    if (cnt_r == {CW{1'b0}}) begin
                        state_s = FIX;
                    end else begin
                        cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            FIX: begin
                if (abort_s) begin
                    state_s = IDLE;
                end else begin
                    if (is_div_r) begin
                        lo_s = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
                        hi_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
                    end else begin
                        hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_s = prod_fix_s[WIDTH-1:0];
                    end
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, HI/LO and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            dvsr_r    <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            is_div_r  <= is_div_s;
            neg_q_r   <= neg_q_s;
            neg_rem_r <= neg_rem_s;
            dvsr_r    <= dvsr_s;
            acc_r     <= acc_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random ops against a 64-bit arithmetic model.
module tb_muldiv_seq;

    localparam int W = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   funct = 6'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_ABORT_EN
    logic         abort = 1'b0;
`endif

    int           n_checks = 0;
    int           n_fail = 0;
    logic [31:0]  m_hi = 32'd0;
    logic [31:0]  m_lo = 32'd0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef MULDIV_ABORT_EN
        .abort  (abort),
`endif
        .start  (start),
        .funct  (funct),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like MIPS.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb, ua, ub;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p = 64'd0; q = 64'd0; r = 64'd0;
        case (f)
            F_MULT:  p = sa * sb;
            F_MULTU: p = ua * ub;
            F_DIV: begin
                if (b == 32'd0) begin
                    q = a[31] ? 64'd1 : 64'hFFFF_FFFF;
                    r = {32'd0, a};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    q = 64'hFFFF_FFFF;
                    r = {32'd0, a};
                end else begin
                    q = ua / ub;
                    r = ua % ub;
                end
            end
        endcase
        if (f == F_MULT || f == F_MULTU) begin
            eh = p[63:32];
            el = p[31:0];
        end else begin
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Issue one mul/div op, optionally poke a second start mid-run, and check timing and result.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit intrude);
        int edges;
        int busy_cycles;
        bit hold_ok;
        bit seen;
        edges = 0; busy_cycles = 0; hold_ok = 1'b1; seen = 1'b0;
        @(negedge clk);
        start = 1'b1; funct = f; rs_val = a; rt_val = b;
        @(posedge clk);
        #1 start = 1'b0;
        while (edges < 40) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
            if (intrude && edges == 5) begin
                start = 1'b1; funct = F_MULT; rs_val = 32'h0000_1234; rt_val = 32'h0000_5678;
            end
            @(posedge clk);
            #1 start = 1'b0;
            edges++;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(edges), 64'(W + 1));
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(W + 1));
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        logic [31:0] a, b, eh, el;
        logic [5:0]  f;
        bit          any_done;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        run_op("mult_neg", F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", F_DIVU, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_zero_neg", F_DIV, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_0001, 1'b0);

        // Direct HI/LO writes: no busy, no done.
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; rs_val = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
        check("mthi_lo", 64'(lo), 64'(m_lo));
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        m_hi = 32'hA5A5_A5A5;
        start = 1'b1; funct = F_MTLO; rs_val = 32'h3C3C_0F0F;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mtlo_lo", 64'(lo), 64'h3C3C_0F0F);
        check("mtlo_hi", 64'(hi), 64'(m_hi));
        m_lo = 32'h3C3C_0F0F;

        // Unlisted funct is ignored.
        start = 1'b1; funct = 6'b100000; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("bad_funct_busy", 64'(busy), 64'd0);
        check("bad_funct_hi", 64'(hi), 64'(m_hi));
        check("bad_funct_lo", 64'(lo), 64'(m_lo));

        // Second start while busy must not disturb the first op.
        run_op("mult_intrude", F_MULT, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 1'b1);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: f = F_MULT;
                1: f = F_MULTU;
                2: f = F_DIV;
                default: f = F_DIVU;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
            model(f, a, b, eh, el);
            run_op($sformatf("rand%0d_f%0h", i, f), f, a, b, eh, el, 1'b0);
        end

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; funct = F_MTHI; rs_val = 32'h5555_AAAA;
        @(posedge clk);
        #1 start = 1'b0;
        m_hi = 32'h5555_AAAA;
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; rs_val = 32'h0001_0001; rt_val = 32'h0000_0010;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op("after_rst", F_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);

`ifdef MULDIV_ABORT_EN
        // Abort at RUN cycle 5: back to IDLE, HI/LO untouched, no done.
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; rs_val = 32'h0000_0100; rt_val = 32'h0000_0100;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        any_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) any_done = 1'b1;
        end
        check("abort_no_done", 64'(any_done), 64'd0);
        check("abort_hi", 64'(hi), 64'(m_hi));
        check("abort_lo", 64'(lo), 64'(m_lo));
        // Abort in IDLE suppresses a simultaneous start.
        start = 1'b1; abort = 1'b1; funct = F_MTHI; rs_val = 32'h1111_2222;
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        check("abort_idle_hi", 64'(hi), 64'(m_hi));
        check("abort_idle_busy", 64'(busy), 64'd0);
`else
        any_done = 1'b0;
        check("noabort_idle", 64'(busy) | 64'(any_done), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
